// File: rtl/fsm_pkg.sv
// State encoding shared by the shift-out and deshift FSMs of the 03_fsm group.
// Latency: n/a (types only).
// Backpressure: n/a.
package fsm_pkg;

   // Common state encoding; PARITY is only reachable when parity framing is built in
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/fsm_deshift.sv
// Serial-to-parallel receiver: captures a start-framed MSB-first bit stream into a WIDTH-bit word.
// Latency: out/valid appear the cycle after the DONE edge (one edge after the last data/parity bit).
// Backpressure: none; sin_en=0 stalls capture indefinitely, start aborts and restarts a frame.
// Optional: define FSM_DESHIFT_PARITY_EN for a trailing even-parity bit and the parity_err port.
module fsm_deshift
   import fsm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] out,
   output logic             valid,
   output logic             busy
`ifdef FSM_DESHIFT_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   fsm_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
`ifdef FSM_DESHIFT_PARITY_EN
   logic             par_bit;
`endif

   // Frame FSM with shift register, bit counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         out   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
`ifdef FSM_DESHIFT_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         // Strobes default low so they never last more than one cycle
         valid <= 1'b0;
`ifdef FSM_DESHIFT_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  shreg <= '0;
                  busy  <= 1'b1;
               end
            end

            SHIFT: begin
               // start wins over a coincident qualified bit: that bit is discarded
               if (start) begin
                  cnt   <= '0;
                  shreg <= '0;
               end else if (sin_en) begin
                  shreg <= {shreg[WIDTH-2:0], sin};
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST) begin
`ifdef FSM_DESHIFT_PARITY_EN
                     state <= PARITY;
`else
                     state <= DONE;
`endif
                  end
               end
            end

`ifdef FSM_DESHIFT_PARITY_EN
            PARITY: begin
               if (start) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  shreg <= '0;
               end else if (sin_en) begin
                  par_bit <= sin;
                  state   <= DONE;
               end
            end
`endif

            DONE: begin
               // Only place out is written, so partial frames never leak onto it
               out   <= shreg;
               valid <= 1'b1;
`ifdef FSM_DESHIFT_PARITY_EN
               parity_err <= (^shreg) != par_bit;
`endif
               if (start) begin
                  // Back-to-back frame: skip IDLE and keep busy asserted
                  state <= SHIFT;
                  cnt   <= '0;
                  shreg <= '0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_deshift.sv
// Scoreboard bench for fsm_deshift: stimulus pushes expected words, a monitor pops on valid.
// Latency: checks valid one edge after the DONE edge.
// Backpressure: exercises sin_en gaps, restart and mid-frame reset.
module tb_fsm_deshift;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic             perr;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sin;
   logic             sin_en;
   logic [WIDTH-1:0] out;
   logic             valid;
   logic             busy;
`ifdef FSM_DESHIFT_PARITY_EN
   logic             parity_err;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];

   fsm_deshift #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sin       (sin),
      .sin_en    (sin_en),
      .out       (out),
      .valid     (valid),
      .busy      (busy)
`ifdef FSM_DESHIFT_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic s, input logic en);
      start  = st;
      sin    = s;
      sin_en = en;
      @(posedge clk);
      #1;
   endtask

   // Sends start then the four bits of d MSB first, one qualified bit per cycle
   task automatic frame(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] v;
      v = d;
      drive(1'b1, 1'b0, 1'b0);
      for (int i = WIDTH - 1; i >= 0; i--) drive(1'b0, v[i], 1'b1);
   endtask

   // Monitor: every valid must match the oldest expected word
   always @(negedge clk) begin
      if (rst && valid) begin
         if (expq.size() == 0) begin
            chk("unexpected_valid", 32'(out), 32'hdead);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("sb_out", 32'(out), 32'(e.dat));
`ifdef FSM_DESHIFT_PARITY_EN
            chk("sb_parity_err", 32'(parity_err), 32'(e.perr));
`endif
         end
      end
   end

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      sin    = 1'b0;
      sin_en = 1'b0;

      // Reset held 3 cycles with inputs toggling
      for (int i = 0; i < 3; i++) begin
         drive(1'(i % 2 == 0), 1'(i % 2 == 1), 1'b1);
         chk("rst_out", 32'(out), 32'h0);
         chk("rst_valid", 32'(valid), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      chk("idle_busy", 32'(busy), 32'h0);

`ifndef FSM_DESHIFT_PARITY_EN
      // Basic frame with exact timing checks
      expq.push_back('{dat: 4'b1101, perr: 1'b0});
      drive(1'b1, 1'b0, 1'b0);
      chk("busy_after_start", 32'(busy), 32'h1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      chk("basic_valid_early", 32'(valid), 32'h0);
      chk("basic_busy_done", 32'(busy), 32'h1);
      drive(1'b0, 1'b0, 1'b0);
      chk("basic_valid", 32'(valid), 32'h1);
      chk("basic_out", 32'(out), 32'hd);
      chk("basic_busy_fall", 32'(busy), 32'h0);
      drive(1'b0, 1'b0, 1'b0);
      chk("basic_valid_pulse", 32'(valid), 32'h0);
      chk("basic_out_hold", 32'(out), 32'hd);

      // Gapped input: sin_en low between bits, sin noise while unqualified
      expq.push_back('{dat: 4'b1101, perr: 1'b0});
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      chk("gap_no_early_valid", 32'(valid), 32'h0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // Restart mid-frame; start also discards a coincident qualified bit
      expq.push_back('{dat: 4'b0110, perr: 1'b0});
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("restart_out", 32'(out), 32'h6);
      drive(1'b0, 1'b0, 1'b0);

      // Back-to-back: start during DONE goes straight to the next frame
      expq.push_back('{dat: 4'b1010, perr: 1'b0});
      expq.push_back('{dat: 4'b0011, perr: 1'b0});
      frame(4'b1010);
      drive(1'b1, 1'b0, 1'b0);
      chk("b2b_busy_held", 32'(busy), 32'h1);
      chk("b2b_first_out", 32'(out), 32'ha);
      drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("b2b_second_out", 32'(out), 32'h3);
      drive(1'b0, 1'b0, 1'b0);

      // Reset mid-frame: no valid, everything cleared
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_out", 32'(out), 32'h0);
      chk("midrst_valid", 32'(valid), 32'h0);
`else
      // Parity frames: 1101 has odd weight, so parity bit 1 is correct
      expq.push_back('{dat: 4'b1101, perr: 1'b0});
      frame(4'b1101);
      chk("par_wait_valid", 32'(valid), 32'h0);
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("par_ok_out", 32'(out), 32'hd);
      chk("par_ok_err", 32'(parity_err), 32'h0);
      drive(1'b0, 1'b0, 1'b0);

      expq.push_back('{dat: 4'b1101, perr: 1'b1});
      frame(4'b1101);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("par_bad_out", 32'(out), 32'hd);
      chk("par_bad_err", 32'(parity_err), 32'h1);
      drive(1'b0, 1'b0, 1'b0);
      chk("par_err_pulse", 32'(parity_err), 32'h0);
      chk("par_busy_fall", 32'(busy), 32'h0);
`endif

      drive(1'b0, 1'b0, 1'b0);
      chk("sb_drained", 32'(expq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
